// File: rtl/approx_mon_pkg.sv
// rtl/approx_mon_pkg.sv - shared widths and FSM state type for the approximate-multiplier error monitor
package approx_mon_pkg;

  localparam int W     = 16;
  localparam int CNT_W = 32;
  localparam int ACC_W = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } mon_state_t;

endpackage

// File: rtl/approx_err_monitor_if.sv
// rtl/approx_err_monitor_if.sv - sample handshake bus carrying operands and approximate product
interface approx_err_monitor_if #(
  parameter int W = approx_mon_pkg::W
) ();

  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [2*W-1:0] prod;

  modport master (output in_valid, output a, output b, output prod, input in_ready);
  modport slave  (input in_valid, input a, input b, input prod, output in_ready);

endinterface

// File: rtl/approx_err_calc.sv
// rtl/approx_err_calc.sv - stages S1-S2: register the sample, form exact product, signed diff and |diff|
module approx_err_calc #(
  parameter int W = approx_mon_pkg::W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  smp_valid,
  input  logic [W-1:0]          a,
  input  logic [W-1:0]          b,
  input  logic [2*W-1:0]        prod,
  output logic                  res_valid,
  output logic [W-1:0]          res_a,
  output logic [W-1:0]          res_b,
  output logic signed [2*W:0]   diff,
  output logic [2*W-1:0]        ed,
  output logic                  ne
);

  logic                s1_valid;
  logic [W-1:0]        s1_a;
  logic [W-1:0]        s1_b;
  logic [2*W-1:0]      s1_prod;
  logic [2*W-1:0]      exact;
  logic signed [2*W:0] diff_c;

  assign exact  = (2*W)'(s1_a) * (2*W)'(s1_b);
  // One extra bit keeps the sign; the magnitude of a 2W-bit difference always fits in 2W bits.
  assign diff_c = $signed({1'b0, s1_prod}) - $signed({1'b0, exact});

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_prod   <= '0;
      res_valid <= 1'b0;
      res_a     <= '0;
      res_b     <= '0;
      diff      <= '0;
      ed        <= '0;
      ne        <= 1'b0;
    end else begin
      s1_valid  <= smp_valid;
      s1_a      <= a;
      s1_b      <= b;
      s1_prod   <= prod;
      res_valid <= s1_valid;
      res_a     <= s1_a;
      res_b     <= s1_b;
      diff      <= diff_c;
      ed        <= diff_c[2*W] ? (2*W)'(-diff_c) : diff_c[2*W-1:0];
      ne        <= (diff_c != '0);
    end
  end

endmodule

// File: rtl/approx_err_monitor.sv
// rtl/approx_err_monitor.sv - windowed error statistics for an approximate multiplier under test
module approx_err_monitor #(
  parameter int W     = approx_mon_pkg::W,
  parameter int CNT_W = approx_mon_pkg::CNT_W,
  parameter int ACC_W = approx_mon_pkg::ACC_W
) (
  input  logic                 clk,
  input  logic                 rst,
  approx_err_monitor_if.slave  smp,
  input  logic                 start,
  input  logic [CNT_W-1:0]     win_len,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     smp_cnt,
  output logic [CNT_W-1:0]     err_cnt,
  output logic [ACC_W-1:0]     sum_ed,
  output logic [ACC_W-1:0]     sum_bias,
  output logic [2*W-1:0]       max_ed,
  output logic [W-1:0]         max_a,
  output logic [W-1:0]         max_b
);

  import approx_mon_pkg::*;

  mon_state_t          state, state_nxt;
  logic [CNT_W-1:0]    win_q;
  logic [CNT_W-1:0]    issued;
  logic                ready_c, accept, clr, done_nxt;
  logic                res_valid, res_ne;
  logic [W-1:0]        res_a, res_b;
  logic signed [2*W:0] res_diff;
  logic [2*W-1:0]      res_ed;

  approx_err_calc #(.W(W)) u_calc (
    .clk       (clk),
    .rst       (rst),
    .smp_valid (accept),
    .a         (smp.a),
    .b         (smp.b),
    .prod      (smp.prod),
    .res_valid (res_valid),
    .res_a     (res_a),
    .res_b     (res_b),
    .diff      (res_diff),
    .ed        (res_ed),
    .ne        (res_ne)
  );

  assign smp.in_ready = ready_c;
  assign accept       = smp.in_valid && ready_c;
  assign busy         = (state == RUN) || (state == DRAIN);

  always_comb begin
    state_nxt = state;
    ready_c   = 1'b0;
    clr       = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE, DONE: begin
        // A start coinciding with the done pulse is ignored so the host can see the result first.
        if (start && !done) begin
          clr = 1'b1;
          if (win_len == '0) begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = RUN;
          end
        end
      end
      RUN: begin
        ready_c = (issued < win_q);
        if (smp.in_valid && ready_c && (issued + CNT_W'(1) == win_q)) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (res_valid && (smp_cnt + CNT_W'(1) == win_q)) begin
          state_nxt = DONE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      done     <= 1'b0;
      win_q    <= '0;
      issued   <= '0;
      smp_cnt  <= '0;
      err_cnt  <= '0;
      sum_ed   <= '0;
      sum_bias <= '0;
      max_ed   <= '0;
      max_a    <= '0;
      max_b    <= '0;
    end else begin
      state <= state_nxt;
      done  <= done_nxt;
      if (clr) begin
        win_q    <= win_len;
        issued   <= '0;
        smp_cnt  <= '0;
        err_cnt  <= '0;
        sum_ed   <= '0;
        sum_bias <= '0;
        max_ed   <= '0;
        max_a    <= '0;
        max_b    <= '0;
      end else begin
        if (accept) issued <= issued + CNT_W'(1);
        if (res_valid) begin
          smp_cnt  <= smp_cnt + CNT_W'(1);
          err_cnt  <= err_cnt + CNT_W'(res_ne);
          sum_ed   <= sum_ed + ACC_W'(res_ed);
          sum_bias <= sum_bias + ACC_W'(res_diff);
          if (res_ed > max_ed) begin
            max_ed <= res_ed;
            max_a  <= res_a;
            max_b  <= res_b;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_approx_err_monitor.sv
// tb/tb_approx_err_monitor.sv - scoreboard bench with randomized samples and a plain-arithmetic reference
module tb_approx_err_monitor;

  localparam int TW = 16;
  localparam int TC = 32;
  localparam int TA = 64;

  typedef struct {
    int     cyc;
    longint smp, err, sed, sbias, med;
    int     ma, mb;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [TC-1:0] win_len;
  logic          busy, done;
  logic [TC-1:0] smp_cnt, err_cnt;
  logic [TA-1:0] sum_ed, sum_bias;
  logic [2*TW-1:0] max_ed;
  logic [TW-1:0] max_a, max_b;

  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  int unsigned qa[$], qb[$], qp[$];
  bit   pat[8] = '{1, 0, 1, 1, 0, 1, 1, 1};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  approx_err_monitor_if #(.W(TW)) sif ();

  approx_err_monitor #(.W(TW), .CNT_W(TC), .ACC_W(TA)) dut (
    .clk      (clk),
    .rst      (rst),
    .smp      (sif),
    .start    (start),
    .win_len  (win_len),
    .busy     (busy),
    .done     (done),
    .smp_cnt  (smp_cnt),
    .err_cnt  (err_cnt),
    .sum_ed   (sum_ed),
    .sum_bias (sum_bias),
    .max_ed   (max_ed),
    .max_a    (max_a),
    .max_b    (max_b)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_zero(input string p);
    check({p, "_in_ready"}, 64'(sif.in_ready), 0);
    check({p, "_busy"}, 64'(busy), 0);
    check({p, "_done"}, 64'(done), 0);
    check({p, "_smp_cnt"}, 64'(smp_cnt), 0);
    check({p, "_err_cnt"}, 64'(err_cnt), 0);
    check({p, "_sum_ed"}, sum_ed, 0);
    check({p, "_sum_bias"}, sum_bias, 0);
    check({p, "_max_ed"}, 64'(max_ed), 0);
    check({p, "_max_a"}, 64'(max_a), 0);
    check({p, "_max_b"}, 64'(max_b), 0);
  endtask

  // Scoreboard monitor: every done pulse must match the oldest expected window result.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'(1), 64'(0));
      end else begin
        mon_e = exp_q.pop_front();
        check("done_cycle", 64'(cyc), 64'(mon_e.cyc));
        check("busy_at_done", 64'(busy), 0);
        check("smp_cnt", 64'(smp_cnt), mon_e.smp);
        check("err_cnt", 64'(err_cnt), mon_e.err);
        check("sum_ed", sum_ed, mon_e.sed);
        check("sum_bias", sum_bias, mon_e.sbias);
        check("max_ed", 64'(max_ed), mon_e.med);
        check("max_a", 64'(max_a), 64'(mon_e.ma));
        check("max_b", 64'(max_b), 64'(mon_e.mb));
      end
    end
  end

  task automatic pick_sample(output int unsigned va, output int unsigned vb, output int unsigned vp);
    longint ex;
    if (qa.size() != 0) begin
      va = qa.pop_front(); vb = qb.pop_front(); vp = qp.pop_front();
    end else begin
      va = ($urandom_range(0, 7) == 0) ? 65535 : $urandom_range(0, 65535);
      vb = $urandom_range(0, 65535);
      ex = longint'(va) * longint'(vb);
      case ($urandom_range(0, 3))
        0: vp = 32'(ex);
        1: vp = 32'(ex + longint'($urandom_range(0, 8)) - 4);
        2: vp = $urandom;
        default: vp = 32'(ex) ^ (32'd1 << $urandom_range(0, 31));
      endcase
    end
  endtask

  task automatic push_smp(input int unsigned va, input int unsigned vb, input int unsigned vp);
    qa.push_back(va); qb.push_back(vb); qp.push_back(vp);
  endtask

  // vmode: 0 valid every cycle, 1 fixed toggle pattern, 2 random valid.
  task automatic run_window(input int n, input int vmode, input bit start_mid, input bit start_at_done);
    exp_t e;
    int acc = 0;
    int k = 0;
    int done_cyc;
    bit v;
    int unsigned va, vb, vp;
    longint ex, d, edv;
    e = '{default: 0};
    @(posedge clk); #1;
    start = 1'b1; win_len = TC'(n); sif.in_valid = 1'b0;
    done_cyc = cyc + 1;
    if (n == 0) begin
      e.cyc = done_cyc;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    start = 1'b0;
    while (acc < n) begin
      v = (vmode == 0) ? 1'b1 : (vmode == 1) ? pat[k % 8] : 1'($urandom_range(0, 1));
      pick_sample(va, vb, vp);
      sif.in_valid = v; sif.a = TW'(va); sif.b = TW'(vb); sif.prod = vp;
      if (start_mid && k == 1) begin start = 1'b1; win_len = TC'(n + 7); end
      else start = 1'b0;
      @(negedge clk);
      check("in_ready_run", 64'(sif.in_ready), 64'(1));
      check("busy_run", 64'(busy), 64'(1));
      if (v) begin
        ex  = longint'(va) * longint'(vb);
        d   = longint'(vp) - ex;
        edv = (d < 0) ? -d : d;
        e.smp++;
        if (d != 0) e.err++;
        e.sed   += edv;
        e.sbias += d;
        if (edv > e.med) begin e.med = edv; e.ma = int'(va); e.mb = int'(vb); end
        acc++;
        if (acc == n) begin
          e.cyc = cyc + 3;
          done_cyc = e.cyc;
          exp_q.push_back(e);
        end
      end
      k++;
      @(posedge clk); #1;
    end
    start = 1'b0;
    pick_sample(va, vb, vp);
    sif.in_valid = 1'b1; sif.a = TW'(va); sif.b = TW'(vb); sif.prod = vp;
    @(negedge clk);
    check("in_ready_after", 64'(sif.in_ready), 64'(0));
    @(posedge clk); #1;
    sif.in_valid = 1'b0;
    if (start_at_done) begin
      while (cyc < done_cyc) begin @(posedge clk); #1; end
      start = 1'b1; win_len = TC'(3);
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      check("start_at_done_busy", 64'(busy), 64'(0));
      check("start_at_done_ready", 64'(sif.in_ready), 64'(0));
    end
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      check("done_timeout", 64'(exp_q.size()), 64'(0));
      exp_q.delete();
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    int unsigned va, vb, vp;
    rst = 1'b1; start = 1'b0; win_len = '0;
    sif.in_valid = 1'b0; sif.a = '0; sif.b = '0; sif.prod = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_zero("reset");

    push_smp(3, 5, 15); push_smp(7, 9, 63); push_smp(100, 200, 20000); push_smp(0, 1234, 0);
    run_window(4, 0, 1'b0, 1'b0);

    push_smp(10, 10, 98); push_smp(2, 3, 7); push_smp(4, 4, 16);
    run_window(3, 0, 1'b0, 1'b0);
    check("errs_err_cnt", 64'(err_cnt), 64'd2);
    check("errs_sum_ed", sum_ed, 64'd3);
    check("errs_sum_bias", sum_bias, 64'hFFFF_FFFF_FFFF_FFFF);
    check("errs_max_ed", 64'(max_ed), 64'd2);
    check("errs_max_a", 64'(max_a), 64'd10);
    check("errs_max_b", 64'(max_b), 64'd10);

    push_smp(65535, 65535, 0); push_smp(65535, 65535, 0);
    run_window(2, 0, 1'b0, 1'b1);
    check("ext_max_ed", 64'(max_ed), 64'hFFFE_0001);
    check("ext_max_a", 64'(max_a), 64'd65535);
    check("ext_sum_ed", sum_ed, 64'h1_FFFC_0002);
    check("ext_sum_bias", sum_bias, -64'sh1_FFFC_0002);

    run_window(5, 1, 1'b1, 1'b0);
    run_window(0, 0, 1'b0, 1'b0);
    @(negedge clk);
    check("zero_win_busy", 64'(busy), 64'(0));

    for (int i = 0; i < 6; i++) run_window(int'($urandom_range(1, 12)), 2, 1'b0, 1'b0);

    @(posedge clk); #1;
    start = 1'b1; win_len = TC'(4);
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      pick_sample(va, vb, vp);
      sif.in_valid = 1'b1; sif.a = TW'(va); sif.b = TW'(vb); sif.prod = vp;
      @(posedge clk); #1;
    end
    sif.in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_zero("midrst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("midrst_flush_smp_cnt", 64'(smp_cnt), 64'(0));
    check("midrst_flush_max_ed", 64'(max_ed), 64'(0));

    run_window(1, 0, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/approx_err_monitor.md
# approx_err_monitor

Downstream statistics stage for the 16x16 approximate multipliers. Each cycle it takes an operand pair and the approximate product that a combinational multiplier computes from that pair. It forms the exact product internally and accumulates error metrics over a programmable window of samples. Results are held for readout by the characterisation bench or FPGA host logic.

## Interface
Parameters:
- `W`, default 16: operand width. Product width is `2*W`.
- `CNT_W`, default 32: width of the window length, sample counter and error counter.
- `ACC_W`, default 64: width of the sum accumulators.

Ports (name, direction, width, meaning):
- `clk`, in, 1: single clock.
- `rst`, in, 1: synchronous, active-high reset.
- `start`, in, 1: begin a window. Clears all statistics and latches `win_len`.
- `win_len`, in, `CNT_W`: number of samples in the window.
- `in_valid`, in, 1: `a`, `b` and `prod` are valid this cycle.
- `in_ready`, out, 1: the block accepts a sample this cycle.
- `a`, in, `W`: operand A.
- `b`, in, `W`: operand B.
- `prod`, in, `2W`: approximate product of `a` and `b` from the multiplier under test.
- `busy`, out, 1: state is RUN or DRAIN.
- `done`, out, 1: one-cycle pulse when the final sample has been accumulated.
- `smp_cnt`, out, `CNT_W`: number of samples accumulated.
- `err_cnt`, out, `CNT_W`: number of samples with `prod != a*b`.
- `sum_ed`, out, `ACC_W`: sum of absolute error distances, |prod − a*b|.
- `sum_bias`, out, `ACC_W`: signed two's-complement sum of (prod − a*b).
- `max_ed`, out, `2W`: largest absolute error distance seen in the window.
- `max_a`, out, `W`: operand A of the first sample that reached `max_ed`.
- `max_b`, out, `W`: operand B of the first sample that reached `max_ed`.

## Operation
- The FSM has four states: IDLE, RUN, DRAIN and DONE. Reset enters IDLE.
- IDLE or DONE, `start`=1:
  - Clear all statistics, `acc_cnt` and `issued`. Latch `win_len`.
  - If `win_len`=0, go to DONE and pulse `done` in the next cycle.
  - Otherwise go to RUN.
- RUN:
  - `in_ready`=1 while `issued` < `win_len`. A sample is accepted when `in_valid && in_ready`; each acceptance increments `issued`.
  - When `issued` reaches `win_len`, deassert `in_ready` and go to DRAIN.
- DRAIN: wait until `acc_cnt` equals the latched `win_len`. Then go to DONE and pulse `done` in the same cycle as the final accumulator update.
- DONE: outputs hold until the next `start` or `rst`.
- `start` is ignored in RUN and DRAIN.
- `in_ready`=0 in IDLE, DRAIN and DONE. `in_valid` without `in_ready` is dropped silently.
- Pipeline, 3 stages:
  - S1: register `a`, `b`, `prod`. Compute the exact product `a*b` (unsigned, `2W` bits).
  - S2: `diff` = prod − exact, sign-extended to `2W+1` bits. `ed` = |diff|, which always fits in `2W` bits. `ne` = (diff ≠ 0).
  - S3: update the statistics.
    - `smp_cnt` += 1.
    - `err_cnt` += `ne`.
    - `sum_ed` += `ed`, zero-extended.
    - `sum_bias` += `diff`, sign-extended.
    - If `ed` > `max_ed` (strictly greater), update `max_ed`, `max_a` and `max_b`. Ties keep the earliest sample.
- Arithmetic: the accumulators wrap modulo 2^`ACC_W`. With the default widths overflow cannot occur for `win_len` < 2^32.
- `rst` mid-window: the pipeline is flushed, every output clears, and the FSM returns to IDLE. When `rst` and `start` are asserted together, `rst` wins.

## Timing
- Reset values: `in_ready`=0, `busy`=0, `done`=0; `smp_cnt`, `err_cnt`, `sum_ed`, `sum_bias`, `max_ed`, `max_a`, `max_b` are all 0.
- Latency: a sample accepted in cycle t is reflected in the statistic outputs at cycle t+3.
- Throughput: one sample per cycle.
- A window of N back-to-back samples started at cycle s:
  - `in_ready` is high in cycles s+1 … s+N.
  - `done` pulses at cycle s+N+3.
- `busy` rises the cycle after `start` and falls in the same cycle that `done` pulses.
- `start` pulsed in the same cycle as `done` is ignored. `start` is honoured from DONE in the following cycle.
- No combinational path exists from the `a`, `b`, `prod` inputs to any output. `in_ready` depends only on registered state.

## Structure
- Package `approx_mon_pkg`:
  - state enum `mon_state_t` (IDLE, RUN, DRAIN, DONE);
  - default width constants `W`, `CNT_W`, `ACC_W`.
- Sub-module `approx_err_calc`: implements stages S1–S2. It takes `a`, `b`, `prod` and a valid bit, and produces `diff`, `ed`, `ne`, the registered `a` and `b`, and a valid bit.
- The top level holds the FSM, the counters and the S3 accumulators.

## Test plan
- Exact feed, `win_len`=4, four samples where `prod`=`a*b`, for example (3,5,15) → `smp_cnt`=4, `err_cnt`=0, `sum_ed`=0, `max_ed`=0, `done` at s+7.
- Errors, `win_len`=3:
  - samples (10,10,98), (2,3,7), (4,4,16);
  - required result: `err_cnt`=2, `sum_ed`=3, `sum_bias`=−1, `max_ed`=2, `max_a`=10, `max_b`=10.
- Tie and extremes, `win_len`=2:
  - samples (65535,65535,0) then (65535,65535,0);
  - required result: `max_ed`=0xFFFE0001 with the first sample's operands kept, `sum_ed`=0x1FFFC0002, `sum_bias`=−0x1FFFC0002.
- Handshake: `win_len`=5 with `in_valid` toggling 1,0,1,1,0,1,1,1 → exactly 5 samples accepted, `in_ready` drops after the 5th acceptance, and the extra valid sample is dropped.
- `win_len`=0 → DONE with a single `done` pulse and all statistics 0. A `start` asserted during RUN has no effect.
- `rst` asserted after 2 of 4 samples → all outputs are 0 the next cycle and state is IDLE. A new window of 1 sample after that completes correctly.
